// File: rtl/bp_pkg.sv
// Shared constants and helpers for the fetch-stage branch predictor.
package bp_pkg;

  // 2-bit saturating counter encodings
  localparam logic [1:0] SNT = 2'd0;
  localparam logic [1:0] WNT = 2'd1;
  localparam logic [1:0] WT  = 2'd2;
  localparam logic [1:0] ST  = 2'd3;

  // Byte distance to the sequential next instruction
  localparam int PC_STEP = 4;

  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction

  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction

  // Table index: word-address bits directly above the byte offset.
  // Widths are passed in so the caller can truncate to its own parameters.
  function automatic logic [31:0] pc_idx(input logic [31:0] pc, input int idx_w);
    return (pc >> 2) & ((32'd1 << idx_w) - 32'd1);
  endfunction

  // BTB tag: everything above the index
  function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_w);
    return pc >> (idx_w + 2);
  endfunction

endpackage

// File: rtl/bp_table.sv
// Direct-mapped counter + BTB storage: one async read port, one sync write
// port, sync reset that clears counters to weakly-not-taken and invalidates.
module bp_table
  import bp_pkg::*;
#(
  parameter int PC_W  = 13,
  parameter int IDX_W = 6,
  parameter int TAG_W = PC_W - 2 - IDX_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [IDX_W-1:0] ridx,
  output logic [1:0]       rctr,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output logic [PC_W-1:0]  rtarget,
  output logic             rjmp,
  input  logic             we,
  input  logic             wbtb,
  input  logic [IDX_W-1:0] widx,
  input  logic [1:0]       wctr,
  input  logic [TAG_W-1:0] wtag,
  input  logic [PC_W-1:0]  wtarget,
  input  logic             wjmp
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]       ctr    [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [TAG_W-1:0] tag    [DEPTH];
  logic [PC_W-1:0]  target [DEPTH];
  logic [DEPTH-1:0] jmp;

  // Async read; a same-cycle write is not bypassed
  assign rctr    = ctr[ridx];
  assign rvalid  = valid[ridx];
  assign rtag    = tag[ridx];
  assign rtarget = target[ridx];
  assign rjmp    = jmp[ridx];

  // Counters and valid bits: reset-cleared, written on every update
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) ctr[i] <= WNT;
      valid <= '0;
    end else if (we) begin
      ctr[widx] <= wctr;
      if (wbtb) valid[widx] <= 1'b1;
    end
  end

  // BTB payload: no reset needed, guarded by valid
  always_ff @(posedge CLK) begin
    if (!RST && we && wbtb) begin
      tag[widx]    <= wtag;
      target[widx] <= wtarget;
      jmp[widx]    <= wjmp;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage next-PC prediction plus execute-stage resolution, flush
// generation, table update and performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W  = 13,
  parameter int IDX_W = 6,
  parameter int TAG_W = PC_W - 2 - IDX_W
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [PC_W-1:0] pcF,
  output logic [PC_W-1:0] predpcF,
  output logic [1:0]      stateF,
  input  logic [PC_W-1:0] pcD,
  input  logic            ctrlE,
  input  logic            jumpE,
  input  logic            takenE,
  input  logic [PC_W-1:0] pcE,
  input  logic [PC_W-1:0] targetE,
  input  logic [1:0]      stateE,
  output logic            fail_predictE,
  output logic [PC_W-1:0] nextpc,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     miss_cnt
);

  logic [IDX_W-1:0] idxF, idxE;
  logic [TAG_W-1:0] tagF, tagE;
  logic [1:0]       rctr;
  logic             rvalid, rjmp, hit;
  logic [TAG_W-1:0] rtag;
  logic [PC_W-1:0]  rtarget;
  logic             squash_q, upd;

  assign idxF = IDX_W'(pc_idx(32'(pcF), IDX_W));
  assign tagF = TAG_W'(pc_tag(32'(pcF), IDX_W));
  assign idxE = IDX_W'(pc_idx(32'(pcE), IDX_W));
  assign tagE = TAG_W'(pc_tag(32'(pcE), IDX_W));

  bp_table #(.PC_W(PC_W), .IDX_W(IDX_W), .TAG_W(TAG_W)) u_table (
    .CLK     (CLK),
    .RST     (RST),
    .ridx    (idxF),
    .rctr    (rctr),
    .rvalid  (rvalid),
    .rtag    (rtag),
    .rtarget (rtarget),
    .rjmp    (rjmp),
    .we      (upd),
    .wbtb    (takenE),
    .widx    (idxE),
    .wctr    (takenE ? sat_inc(stateE) : sat_dec(stateE)),
    .wtag    (tagE),
    .wtarget (targetE),
    .wjmp    (jumpE)
  );

  // Lookup: redirect only on a tag hit that is a jump or predicted taken
  assign hit     = rvalid && (rtag == tagF);
  assign stateF  = rctr;
  assign predpcF = (hit && (rjmp || rctr[1])) ? rtarget : pcF + PC_W'(PC_STEP);

  // Resolution: the instruction in D is what we fetched after E; if it is
  // not the true successor, flush. The bubble following a flush is ignored.
  assign nextpc        = takenE ? targetE : pcE + PC_W'(PC_STEP);
  assign upd           = ctrlE && !squash_q && !RST;
  assign fail_predictE = upd && (nextpc != pcD);

  // Squash tracker and wrapping performance counters
  always_ff @(posedge CLK) begin
    if (RST) begin
      squash_q   <= 1'b0;
      branch_cnt <= '0;
      miss_cnt   <= '0;
    end else begin
      squash_q <= fail_predictE;
      if (upd)           branch_cnt <= branch_cnt + 32'd1;
      if (fail_predictE) miss_cnt   <= miss_cnt + 32'd1;
    end
  end

endmodule
